// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: BCD mm:ss kitchen countdown timer with start/pause, alarm and alarm auto-timeout
module cook_timer_ctrl #(
   parameter int ALARM_TIMEOUT_SEC = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sec_tick,
   input  logic       btn_start,
   input  logic       btn_inc_min,
   input  logic       btn_inc_sec,
   input  logic       btn_clear,
   output logic [3:0] min10,
   output logic [3:0] min1,
   output logic [3:0] sec10,
   output logic [3:0] sec1,
   output logic       running,
   output logic       alarm
);
   localparam int CW = ALARM_TIMEOUT_SEC > 0 ? $clog2(ALARM_TIMEOUT_SEC + 1) : 1;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
   state_t state, state_nx;
   logic [7:0] mins, secs, mins_nx, secs_nx;
   logic [CW-1:0] acnt, acnt_nx;
   logic legal, tm_nz, tm_one, timeout, running_nx, alarm_nx;
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return v[3:0] == 4'd9 ? (v[7:4] == 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0}) : {v[7:4], v[3:0] + 4'd1};
   endfunction
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      return v[3:0] != 4'd0 ? {v[7:4], v[3:0] - 4'd1} : v[7:4] != 4'd0 ? {v[7:4] - 4'd1, 4'd9} : 8'h59;
   endfunction
   function automatic logic bcd_ok(input logic [7:0] v);
      return v[7:4] <= 4'd5 && v[3:0] <= 4'd9;
   endfunction
   assign legal   = bcd_ok(mins) && bcd_ok(secs);
   assign tm_nz   = |{mins, secs};
   assign tm_one  = {mins, secs} == 16'h0001;
   assign timeout = ALARM_TIMEOUT_SEC != 0 && sec_tick && acnt == CW'(ALARM_TIMEOUT_SEC - 1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         mins    <= '0;
         secs    <= '0;
         acnt    <= '0;
         running <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         state   <= state_nx;
         mins    <= mins_nx;
         secs    <= secs_nx;
         acnt    <= acnt_nx;
         running <= running_nx;
         alarm   <= alarm_nx;
      end
   end
   // corrupted digits are treated like a clear so the display can never show garbage
   always_comb begin
      state_nx = IDLE;
      if (!btn_clear && legal)
         case (state)
            IDLE:    state_nx = btn_start && tm_nz ? RUN : IDLE;
            RUN:     state_nx = btn_start ? PAUSE : sec_tick && tm_one ? ALARM : RUN;
            PAUSE:   state_nx = btn_start ? RUN : PAUSE;
            ALARM:   state_nx = btn_start || timeout ? IDLE : ALARM;
            default: state_nx = IDLE;
         endcase
   end
   always_comb begin
      mins_nx = mins;
      secs_nx = secs;
      if (btn_clear || !legal) begin
         mins_nx = '0;
         secs_nx = '0;
      end else if (state == IDLE && !btn_start) begin
         mins_nx = btn_inc_min ? bcd_inc(mins) : mins;
         secs_nx = !btn_inc_min && btn_inc_sec ? bcd_inc(secs) : secs;
      end else if (state == RUN && !btn_start && sec_tick) begin
         secs_nx = bcd_dec(secs);
         mins_nx = secs == 8'h00 ? bcd_dec(mins) : mins;
      end
      acnt_nx = state != ALARM || btn_clear ? '0 : sec_tick && ALARM_TIMEOUT_SEC != 0 ? acnt + 1'b1 : acnt;
   end
   always_comb begin
      running_nx = state_nx == RUN;
      alarm_nx   = state_nx == ALARM;
   end
   assign min10 = mins[7:4];
   assign min1  = mins[3:0];
   assign sec10 = secs[7:4];
   assign sec1  = secs[3:0];
endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
- Minute:second countdown timer (kitchen-timer style), max 59:59.
- Sits downstream of the clock tick generator. Consumes its one-cycle `sec_tick` strobe.
- Takes pre-debounced, one-cycle button pulses as inputs.
- Drives BCD digits to the FND display driver and an alarm flag to the buzzer/LED stage.

Parameters:
- ALARM_TIMEOUT_SEC, 10, seconds the alarm stays asserted before auto-return to IDLE. 0 = alarm holds until acknowledged.

Ports:
- clk  in  1  system clock (125 MHz domain, same as tick generator)
- reset_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-clk pulse per second from the clock tick generator
- btn_start  in  1  one-clk pulse: start/pause toggle, also acknowledges alarm
- btn_inc_min  in  1  one-clk pulse: +1 minute while in IDLE
- btn_inc_sec  in  1  one-clk pulse: +1 second while in IDLE
- btn_clear  in  1  one-clk pulse: abort, zero time, go IDLE
- min10  out  4  BCD minutes tens, 0-5
- min1  out  4  BCD minutes units, 0-9
- sec10  out  4  BCD seconds tens, 0-5
- sec1  out  4  BCD seconds units, 0-9
- running  out  1  high while in RUN
- alarm  out  1  high while in ALARM

Behaviour:
- Single clock `clk`; reset is asynchronous and active-low (`reset_n`).
- All outputs and state are registered. All updates occur on posedge clk.
- Reset (`reset_n`=0, async): all digits 0, running=0, alarm=0, state=IDLE, alarm second counter=0.
- States: IDLE, RUN, PAUSE, ALARM.
- Input priority within one cycle: btn_clear > btn_start > btn_inc_min > btn_inc_sec > sec_tick.

IDLE:
- btn_inc_sec: seconds +1 BCD. 59 wraps to 00 with no carry into minutes.
- btn_inc_min: minutes +1 BCD. 59 wraps to 00.
- btn_start with time != 00:00: go to RUN next cycle. With time == 00:00: ignored.
- sec_tick is ignored.

RUN:
- On sec_tick, decrement BCD time by one second.
  - sec1 0 to 9 with borrow; sec10 0 to 5 with borrow into minutes; min1/min10 likewise.
- Tick that takes 00:01 to 00:00: digits show 00:00 and state goes to ALARM on the same edge. alarm=1 and running=0 from the next cycle.
- btn_start: go to PAUSE. A sec_tick in the same cycle is dropped (no decrement).
- Increment buttons are ignored.
- running=1 in RUN only.

PAUSE:
- Time frozen; sec_tick ignored.
- btn_start: back to RUN.
- Increment buttons are ignored.

ALARM:
- alarm=1. Digits hold 00:00.
- Internal counter counts sec_tick pulses. On the tick that reaches ALARM_TIMEOUT_SEC (when nonzero), go to IDLE and set alarm=0.
- btn_start: immediate acknowledge; go to IDLE, alarm=0 next cycle.
- The counter clears on every ALARM entry.

Any state:
- btn_clear: IDLE, digits 00:00, alarm=0, running=0, alarm counter cleared.

Width and safety:
- BCD digits never leave legal ranges.
- Any illegal state encoding recovers to IDLE with zeroed time.

Latency:
- Button to output: 1 clk.
- sec_tick to digit change: 1 clk.

Test Plan:
- reset_n low mid-RUN at 12:34 -> next sampled outputs all 0, running=0, alarm=0, independent of clk. After release, btn_start is ignored (time 00:00).
- IDLE: 60 btn_inc_sec pulses -> sec wraps to 00 on the 60th, minutes stay 00. 3 btn_inc_min then 5 btn_inc_sec -> 03:05.
- From 01:00, btn_start, 1 sec_tick -> 00:59. Run to 00:01 then 1 tick -> 00:00, alarm=1 and running=0 one clk later.
- RUN 00:10: btn_start and sec_tick in the same cycle -> PAUSE, display stays 00:10. Further ticks ignored. btn_start -> RUN resumes from 00:10.
- ALARM with ALARM_TIMEOUT_SEC=10 -> alarm drops after exactly 10 sec_ticks. Repeat with btn_start after 3 ticks -> alarm=0 next clk, state IDLE.
- RUN 45:00: btn_clear and btn_start in the same cycle -> IDLE, 00:00, running=0. ALARM_TIMEOUT_SEC=0 -> alarm stays high after 100 ticks until btn_start.
